regf_wb: RTL and testbench

//  Writeback stage feeding the register file's single write port (we/waddr/wdata).

---
 rtl/regf_wb.sv | 119 +++++++++++
 tb/tb_regf_wb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regf_wb.sv
// Register-file writeback: ALU results take priority over buffered load results;
// a scoreboard tracks destinations with outstanding loads for RAW stalls.
module regf_wb #(
  parameter int DW         = 32,
  parameter int AW         = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_alu_valid,
  input  logic [AW-1:0] i_alu_addr,
  input  logic [DW-1:0] i_alu_data,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_pend_set,
  input  logic [AW-1:0] i_pend_addr,
  output logic [63:0]   o_busy,
  output logic          o_stall,
  output logic [PW:0]   o_fifo_cnt,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata
);

  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic [AW-1:0] REG_PC   = AW'(63);
  localparam logic [PW:0]   FULL     = (PW+1)'(FIFO_DEPTH);

  function automatic logic discard(input logic [AW-1:0] a);
    return (a == REG_ZERO) || (a == REG_PC);
  endfunction

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          alu_win, push, pop;
  logic          vld_p1, src_ld_p1;
  logic [AW-1:0] waddr_p1;
  logic [DW-1:0] wdata_p1;
  logic [63:0]   busy, busy_nxt;

  // Selection: ALU wins unless its destination is discarded; ready ignores same-cycle pops.
  assign o_ld_ready = (cnt != FULL);
  assign o_stall    = (cnt == FULL);
  assign alu_win    = i_alu_valid && !discard(i_alu_addr);
  assign pop        = !alu_win && (cnt != '0);
  assign push       = i_ld_valid && o_ld_ready && !discard(i_ld_addr);

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_ld_addr;
      fifo_data[wr_ptr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // p1: registered write port; address/data hold when nothing commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1    <= 1'b0;
      src_ld_p1 <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
    end else if (alu_win) begin
      vld_p1    <= 1'b1;
      src_ld_p1 <= 1'b0;
      waddr_p1  <= i_alu_addr;
      wdata_p1  <= i_alu_data;
    end else if (pop) begin
      vld_p1    <= 1'b1;
      src_ld_p1 <= 1'b1;
      waddr_p1  <= fifo_addr[rd_ptr];
      wdata_p1  <= fifo_data[rd_ptr];
    end else begin
      vld_p1    <= 1'b0;
      src_ld_p1 <= 1'b0;
    end
  end

  // Clear applied before set so a same-edge set wins.
  always_comb begin
    busy_nxt = busy;
    if (vld_p1 && src_ld_p1) busy_nxt[waddr_p1] = 1'b0;
    if (i_pend_set && !discard(i_pend_addr)) busy_nxt[i_pend_addr] = 1'b1;
    busy_nxt[0]  = 1'b0;
    busy_nxt[63] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  assign o_busy     = busy;
  assign o_fifo_cnt = cnt;
  assign o_we       = vld_p1;
  assign o_waddr    = waddr_p1;
  assign o_wdata    = wdata_p1;

endmodule

// File: tb/tb_regf_wb.sv
// Bench for regf_wb: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the writeback arbitration and scoreboard.
module tb_regf_wb;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, pend_set;
  logic [5:0]  alu_addr, ld_addr, pend_addr;
  logic [31:0] alu_data, ld_data;
  logic        ld_ready, stall, we;
  logic [63:0] busy;
  logic [2:0]  fifo_cnt;
  logic [5:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  logic [37:0] q[$];
  logic        m_we, m_src_ld;
  logic [5:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [63:0] m_busy;

  regf_wb #(.DW(32), .AW(6), .FIFO_DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_addr(alu_addr), .i_alu_data(alu_data),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_pend_set(pend_set), .i_pend_addr(pend_addr),
    .o_busy(busy), .o_stall(stall), .o_fifo_cnt(fifo_cnt),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reg_ok(input logic [5:0] a);
    return a != 6'd0 && a != 6'd63;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_src_ld = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
  endtask

  // One clock edge of the reference behaviour, using inputs held across the edge.
  task automatic model_edge();
    bit ready, alu_win, do_pop, do_push;
    logic [37:0] head;
    logic [63:0] nb;
    ready   = q.size() != D;
    alu_win = alu_valid && reg_ok(alu_addr);
    do_pop  = !alu_win && q.size() > 0;
    do_push = ld_valid && ready && reg_ok(ld_addr);
    nb = m_busy;
    if (m_we && m_src_ld) nb[m_waddr] = 1'b0;
    if (pend_set && reg_ok(pend_addr)) nb[pend_addr] = 1'b1;
    nb[0] = 1'b0; nb[63] = 1'b0;
    m_busy = nb;
    if (alu_win) begin
      m_we = 1; m_src_ld = 0; m_waddr = alu_addr; m_wdata = alu_data;
    end else if (do_pop) begin
      head = q.pop_front();
      m_we = 1; m_src_ld = 1; m_waddr = head[37:32]; m_wdata = head[31:0];
    end else begin
      m_we = 0; m_src_ld = 0;
    end
    if (do_push) q.push_back({ld_addr, ld_data});
  endtask

  task automatic check_all();
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("wdata", wdata, m_wdata);
    check("busy", busy, m_busy);
    check("cnt", fifo_cnt, q.size());
    check("ready", ld_ready, q.size() != D);
    check("stall", stall, q.size() == D);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    check_all();
  endtask

  task automatic idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    pend_set = 0; pend_addr = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ld_ready, 1);
    check("rst_cnt", fifo_cnt, 0);
    step(); step();
    rst_n = 1;
    step();

    // ALU writes, including discarded destinations
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    step();
    check("alu_we", we, 1);
    check("alu_waddr", waddr, 5);
    check("alu_wdata", wdata, 32'hDEADBEEF);
    alu_addr = 0; alu_data = 32'h1111_1111;
    step();
    check("alu0_we", we, 0);
    alu_addr = 63;
    step();
    check("alu63_we", we, 0);
    check("alu63_hold", wdata, 32'hDEADBEEF);
    idle();

    // Load with scoreboard: accept-to-write latency and busy clearing
    pend_set = 1; pend_addr = 7;
    step();
    check("t3_busy7_set", busy[7], 1);
    idle();
    ld_valid = 1; ld_addr = 7; ld_data = 32'h1234;
    step();
    check("t3_we_e0", we, 0);
    idle();
    step();
    check("t3_we_e1", we, 1);
    check("t3_waddr", waddr, 7);
    check("t3_busy7_hold", busy[7], 1);
    step();
    check("t3_busy7_clr", busy[7], 0);

    // Fill FIFO behind continuous ALU traffic, then drain in order
    alu_valid = 1; alu_addr = 10;
    for (int i = 1; i <= 4; i++) begin
      alu_data = 32'hA000 + i;
      ld_valid = 1; ld_addr = 6'(i); ld_data = 32'hB000 + i;
      step();
    end
    check("t4_ready", ld_ready, 0);
    check("t4_stall", stall, 1);
    ld_addr = 20; ld_data = 32'hBAD;
    step();
    check("t4_full_cnt", fifo_cnt, 4);
    idle();
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_drain_we", we, 1);
      check("t4_drain_addr", waddr, i);
      check("t4_drain_stall", stall, 0);
    end
    step();

    // Same-edge set and clear of one busy bit
    pend_set = 1; pend_addr = 9;
    step();
    idle();
    ld_valid = 1; ld_addr = 9; ld_data = 32'h99;
    step();
    idle();
    step();
    check("t5_commit", waddr, 9);
    pend_set = 1; pend_addr = 9;
    step();
    check("t5_busy9", busy[9], 1);
    idle();
    step();

    // Asynchronous reset with three buffered loads
    alu_valid = 1; alu_addr = 11; alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_addr = 6'(30 + i); ld_data = 32'hC0 + i;
      step();
    end
    idle();
    check("t6_cnt_pre", fifo_cnt, 3);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t6_we", we, 0);
    check("t6_cnt", fifo_cnt, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_write", we, 0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_addr  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 6'd0 : 6'd63) : 6'($urandom);
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 0);
      ld_addr   = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
      ld_data   = $urandom;
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = 6'($urandom_range(0, 15));
      step();
    end
    idle();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
